// File: rtl/mem_refill_arbiter_if.sv
// Refill arbiter bus bundle: two cache refill requesters plus one AXI4
// read master (AR and R channels).
// modport slave  : the arbiter's view
// modport master : the environment's view (caches and AXI slave side)
interface mem_refill_arbiter_if #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8
);
   logic                  i_req_i;
   logic [ADDR_WIDTH-1:0] i_addr_i;
   logic [LEN_WIDTH-1:0]  i_len_i;
   logic                  i_gnt_o;
   logic                  i_rvalid_o;

   logic                  d_req_i;
   logic [ADDR_WIDTH-1:0] d_addr_i;
   logic [LEN_WIDTH-1:0]  d_len_i;
   logic                  d_gnt_o;
   logic                  d_rvalid_o;

   logic [DATA_WIDTH-1:0] rdata_o;
   logic                  rlast_o;
   logic                  rerr_o;

   logic [ADDR_WIDTH-1:0] m_araddr_o;
   logic [LEN_WIDTH-1:0]  m_arlen_o;
   logic [1:0]            m_arburst_o;
   logic                  m_arvalid_o;
   logic                  m_arready_i;

   logic [DATA_WIDTH-1:0] m_rdata_i;
   logic [1:0]            m_rresp_i;
   logic                  m_rlast_i;
   logic                  m_rvalid_i;
   logic                  m_rready_o;

   modport slave (
      input  i_req_i, i_addr_i, i_len_i,
      output i_gnt_o, i_rvalid_o,
      input  d_req_i, d_addr_i, d_len_i,
      output d_gnt_o, d_rvalid_o,
      output rdata_o, rlast_o, rerr_o,
      output m_araddr_o, m_arlen_o, m_arburst_o, m_arvalid_o,
      input  m_arready_i,
      input  m_rdata_i, m_rresp_i, m_rlast_i, m_rvalid_i,
      output m_rready_o
   );

   modport master (
      output i_req_i, i_addr_i, i_len_i,
      input  i_gnt_o, i_rvalid_o,
      output d_req_i, d_addr_i, d_len_i,
      input  d_gnt_o, d_rvalid_o,
      input  rdata_o, rlast_o, rerr_o,
      input  m_araddr_o, m_arlen_o, m_arburst_o, m_arvalid_o,
      output m_arready_i,
      output m_rdata_i, m_rresp_i, m_rlast_i, m_rvalid_i,
      input  m_rready_o
   );
endinterface

// File: rtl/mem_refill_arbiter.sv
// Instruction/data cache refill arbiter onto a single AXI4 read master.
// One burst outstanding at a time; beats are forwarded combinationally to
// the requester that owns the burst.
// Build option: KUUGA_ARB_FIXED_PRIO_EN selects fixed priority (instruction
// always wins ties); when undefined, ties alternate round-robin.
// The interface instance must carry the same width parameters as this module.
//
// state | meaning
// IDLE  | no burst outstanding; a pending request is granted this cycle
// ADDR  | AR channel valid with latched address/length, waiting for arready
// DATA  | R channel ready, beats forwarded to owner until rlast
module mem_refill_arbiter #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int LEN_WIDTH  = 8
) (
   input logic                 clk,
   input logic                 rst_n,
   mem_refill_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   state_t                state_q;
   state_t                state_d;
   logic                  owner_d_q;   // 1: data cache owns the burst
   logic                  last_d_q;    // 1: data cache was served last
   logic [ADDR_WIDTH-1:0] araddr_q;
   logic [LEN_WIDTH-1:0]  arlen_q;

   logic                  pick_d;
   logic                  grant;
   logic                  fwd;
   logic [DATA_WIDTH-1:0] rdata_fwd;

   // Winner selection; grant is blocked while reset is asserted so no
   // combinational gnt can escape during reset.
   always_comb begin
`ifdef KUUGA_ARB_FIXED_PRIO_EN
      pick_d = bus.d_req_i && !bus.i_req_i;
`else
      pick_d = bus.d_req_i && (!bus.i_req_i || !last_d_q);
`endif
      grant  = (state_q == ST_IDLE) && (bus.i_req_i || bus.d_req_i) && rst_n;
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Burst context latched at grant time; last-served resets to data so the
   // instruction side wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         owner_d_q <= 1'b0;
         last_d_q  <= 1'b1;
         araddr_q  <= '0;
         arlen_q   <= '0;
      end else if (grant) begin
         owner_d_q <= pick_d;
         last_d_q  <= pick_d;
         araddr_q  <= pick_d ? bus.d_addr_i : bus.i_addr_i;
         arlen_q   <= pick_d ? bus.d_len_i  : bus.i_len_i;
      end
   end

   // Next state and all outputs.
   always_comb begin
      state_d         = state_q;
      bus.i_gnt_o     = 1'b0;
      bus.d_gnt_o     = 1'b0;
      bus.m_arvalid_o = 1'b0;
      bus.m_rready_o  = 1'b0;
      fwd             = 1'b0;
      case (state_q)
         ST_IDLE: begin
            bus.i_gnt_o = grant && !pick_d;
            bus.d_gnt_o = grant && pick_d;
            if (grant) begin
               state_d = ST_ADDR;
            end
         end
         ST_ADDR: begin
            bus.m_arvalid_o = 1'b1;
            if (bus.m_arready_i) begin
               state_d = ST_DATA;
            end
         end
         ST_DATA: begin
            bus.m_rready_o = 1'b1;
            fwd            = bus.m_rvalid_i;
            if (bus.m_rvalid_i && bus.m_rlast_i) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      rdata_fwd       = fwd ? bus.m_rdata_i : '0;
      bus.i_rvalid_o  = fwd && !owner_d_q;
      bus.d_rvalid_o  = fwd && owner_d_q;
      bus.rlast_o     = fwd && bus.m_rlast_i;
      bus.rerr_o      = fwd && (bus.m_rresp_i != 2'b00);
      bus.rdata_o     = rdata_fwd;
      bus.m_araddr_o  = araddr_q;
      bus.m_arlen_o   = arlen_q;
      bus.m_arburst_o = 2'b01;
   end

endmodule

// File: tb/tb_mem_refill_arbiter.sv
// Bench for mem_refill_arbiter: directed scenarios with literal expectations
// followed by randomized traffic against a transaction-level reference model.
module tb_mem_refill_arbiter;
   localparam int AW = 32;
   localparam int DW = 32;
   localparam int LW = 8;
`ifdef KUUGA_ARB_FIXED_PRIO_EN
   localparam bit FIXED = 1'b1;
`else
   localparam bit FIXED = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   mem_refill_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) bus ();

   mem_refill_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_WIDTH(LW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 'h%0h expected 'h%0h at %0t", name, act, exp, $time);
      end
   endtask

   // AXI slave controls: ar_delay<0 random, err_beat -1 random / -2 none.
   int ar_delay = 0;
   bit gaps     = 1'b0;
   int err_beat = -2;
   bit spurious = 1'b0;

   // AXI read slave: accepts one AR, returns len+1 beats.
   initial begin : axi_slave
      int s_left, s_idx, ar_wait, cur_delay;
      bit sending, live, ar_hs, r_hs, present;
      logic [LW-1:0] len_cap;
      s_left = 0; s_idx = 0; ar_wait = 0; cur_delay = 0;
      sending = 1'b0; live = 1'b0;
      bus.m_arready_i = 1'b0;
      bus.m_rvalid_i  = 1'b0;
      bus.m_rlast_i   = 1'b0;
      bus.m_rresp_i   = 2'b00;
      bus.m_rdata_i   = '0;
      forever begin
         @(negedge clk);
         ar_hs   = bus.m_arvalid_o && bus.m_arready_i;
         r_hs    = live && bus.m_rready_o && bus.m_rvalid_i;
         len_cap = bus.m_arlen_o;
         @(posedge clk);
         #1;
         if (!rst_n) begin
            sending = 1'b0; live = 1'b0; ar_wait = 0;
            bus.m_arready_i = 1'b0;
            bus.m_rvalid_i  = 1'b0;
            bus.m_rlast_i   = 1'b0;
            bus.m_rresp_i   = 2'b00;
         end else begin
            if (ar_hs) begin
               sending = 1'b1; live = 1'b0; s_left = int'(len_cap) + 1; s_idx = 0;
            end else if (r_hs) begin
               s_idx++; s_left--; live = 1'b0;
               if (s_left == 0) sending = 1'b0;
            end
            if (sending) begin
               if (!live) begin
                  present = !gaps || ($urandom_range(3) != 0);
                  live = present;
                  bus.m_rvalid_i = present;
                  bus.m_rdata_i  = $urandom;
                  bus.m_rlast_i  = (s_left == 1);
                  if (err_beat == -1)
                     bus.m_rresp_i = ($urandom_range(7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                  else if (err_beat >= 0)
                     bus.m_rresp_i = (s_idx == err_beat) ? 2'b10 : 2'b00;
                  else
                     bus.m_rresp_i = 2'b00;
               end
            end else begin
               bus.m_rvalid_i = spurious && ($urandom_range(3) == 0);
               bus.m_rlast_i  = 1'($urandom_range(1));
               bus.m_rresp_i  = 2'($urandom_range(3));
               bus.m_rdata_i  = $urandom;
            end
            if (bus.m_arvalid_o) begin
               if (ar_wait == 0) cur_delay = (ar_delay < 0) ? $urandom_range(3) : ar_delay;
               bus.m_arready_i = (ar_wait >= cur_delay);
               ar_wait++;
            end else begin
               ar_wait = 0;
               bus.m_arready_i = 1'($urandom_range(1));
            end
         end
      end
   end

   // Reference model: one outstanding burst described as a transaction
   // record; outputs are derived from the record and the current inputs.
   initial begin : model_check
      bit busy, ar_done, own_d, last_d, any, wd, g, rr, f;
      logic [AW-1:0] m_addr;
      logic [LW-1:0] m_len;
      int beats;
      busy = 1'b0; ar_done = 1'b0; own_d = 1'b0; last_d = 1'b1; beats = 0;
      m_addr = '0; m_len = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_arvalid", bus.m_arvalid_o, 0);
            chk("rst_rready", bus.m_rready_o, 0);
            chk("rst_i_rvalid", bus.i_rvalid_o, 0);
            chk("rst_d_rvalid", bus.d_rvalid_o, 0);
            chk("rst_i_gnt", bus.i_gnt_o, 0);
            chk("rst_d_gnt", bus.d_gnt_o, 0);
            chk("rst_arburst", bus.m_arburst_o, 2'b01);
            busy = 1'b0; last_d = 1'b1;
         end else begin
            any = bus.i_req_i || bus.d_req_i;
            wd  = FIXED ? (bus.d_req_i && !bus.i_req_i)
                        : (bus.d_req_i && (!bus.i_req_i || !last_d));
            g   = !busy && any;
            chk("i_gnt", bus.i_gnt_o, g && !wd);
            chk("d_gnt", bus.d_gnt_o, g && wd);
            chk("arvalid", bus.m_arvalid_o, busy && !ar_done);
            if (busy && !ar_done) begin
               chk("araddr", bus.m_araddr_o, m_addr);
               chk("arlen", bus.m_arlen_o, m_len);
            end
            chk("arburst", bus.m_arburst_o, 2'b01);
            rr = busy && ar_done;
            chk("rready", bus.m_rready_o, rr);
            f = rr && bus.m_rvalid_i;
            chk("i_rvalid", bus.i_rvalid_o, f && !own_d);
            chk("d_rvalid", bus.d_rvalid_o, f && own_d);
            chk("rerr", bus.rerr_o, f && (bus.m_rresp_i != 2'b00));
            if (f) begin
               chk("rdata", bus.rdata_o, bus.m_rdata_i);
               chk("rlast", bus.rlast_o, bus.m_rlast_i);
            end
            if (g) begin
               busy = 1'b1; ar_done = 1'b0; own_d = wd; last_d = wd; beats = 0;
               m_addr = wd ? bus.d_addr_i : bus.i_addr_i;
               m_len  = wd ? bus.d_len_i  : bus.i_len_i;
            end else if (busy && !ar_done && bus.m_arready_i) begin
               ar_done = 1'b1;
            end else if (f) begin
               beats++;
               if (bus.m_rlast_i) begin
                  chk("burst_beats", beats, int'(m_len) + 1);
                  busy = 1'b0;
               end
            end
         end
      end
   end

   task automatic clear_reqs();
      bus.i_req_i = 1'b0; bus.i_addr_i = '0; bus.i_len_i = '0;
      bus.d_req_i = 1'b0; bus.d_addr_i = '0; bus.d_len_i = '0;
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      clear_reqs();
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic wait_idle(input string name);
      bit idle = 1'b0;
      for (int c = 0; c < 100 && !idle; c++) begin
         @(negedge clk);
         idle = !bus.m_arvalid_o && !bus.m_rready_o;
      end
      chk(name, idle, 1);
   endtask

   // Counts beats of one burst for the instruction side; returns number of
   // i beats, index (1-based) of the rlast beat, d beats seen, rerr mask.
   task automatic collect_i(output int ib, output int last_at, output int dseen,
                            output logic [7:0] emask);
      ib = 0; last_at = 0; dseen = 0; emask = '0;
      for (int c = 0; c < 30 && last_at == 0; c++) begin
         @(negedge clk);
         if (bus.d_rvalid_o) dseen++;
         if (bus.i_rvalid_o) begin
            if (bus.rerr_o && ib < 8) emask[ib] = 1'b1;
            ib++;
            if (bus.rlast_o) last_at = ib;
         end
      end
   endtask

   initial begin : main
      int ib, last_at, dseen, ng, arv, arlow, gcnt, dcnt;
      logic [7:0] emask;
      bit order[$];
      bit ig, dg;
      clear_reqs();

      // Reset values
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_arvalid", bus.m_arvalid_o, 0);
      chk("reset_arburst", bus.m_arburst_o, 2'b01);
      chk("reset_rready", bus.m_rready_o, 0);
      chk("reset_gnt", {bus.i_gnt_o, bus.d_gnt_o}, 0);
      rst_n = 1'b1;

      // Single instruction burst of four beats, arready immediate
      ar_delay = 0; gaps = 1'b0; err_beat = -2; spurious = 1'b0;
      @(posedge clk); #1;
      bus.i_req_i = 1'b1; bus.i_addr_i = 32'h100; bus.i_len_i = 8'd3;
      @(negedge clk);
      chk("t1_i_gnt", bus.i_gnt_o, 1);
      chk("t1_d_gnt", bus.d_gnt_o, 0);
      @(posedge clk); #1;
      bus.i_req_i = 1'b0;
      @(negedge clk);
      chk("t1_arvalid", bus.m_arvalid_o, 1);
      chk("t1_araddr", bus.m_araddr_o, 32'h100);
      chk("t1_arlen", bus.m_arlen_o, 3);
      collect_i(ib, last_at, dseen, emask);
      chk("t1_i_beats", ib, 4);
      chk("t1_rlast_beat", last_at, 4);
      chk("t1_d_rvalid_seen", dseen, 0);
      wait_idle("t1_idle");

      // Contending requesters for four bursts
      do_reset();
      @(posedge clk); #1;
      bus.i_req_i = 1'b1; bus.i_addr_i = 32'h200; bus.i_len_i = 8'd1;
      bus.d_req_i = 1'b1; bus.d_addr_i = 32'h300; bus.d_len_i = 8'd1;
      ng = 0;
      for (int c = 0; c < 200 && ng < 4; c++) begin
         @(negedge clk);
         if (bus.i_gnt_o) begin order.push_back(1'b0); ng++; end
         if (bus.d_gnt_o) begin order.push_back(1'b1); ng++; end
      end
      @(posedge clk); #1;
      clear_reqs();
      chk("t2_grant_count", ng, 4);
      for (int k = 0; k < 4; k++) begin
         if (k < order.size())
            chk($sformatf("t2_grant_%0d", k), order[k], FIXED ? 1'b0 : ((k % 2) == 1));
      end
      wait_idle("t2_idle");

      // arready withheld for five cycles
      ar_delay = 5;
      @(posedge clk); #1;
      bus.d_req_i = 1'b1; bus.d_addr_i = 32'h4440; bus.d_len_i = 8'd2;
      @(negedge clk);
      chk("t3_d_gnt", bus.d_gnt_o, 1);
      @(posedge clk); #1;
      bus.d_req_i = 1'b0;
      arv = 0; arlow = 0; gcnt = 0;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         if (bus.i_gnt_o || bus.d_gnt_o) gcnt++;
         if (bus.m_arvalid_o) begin
            arv++;
            if (!bus.m_arready_i) arlow++;
            chk("t3_araddr_stable", bus.m_araddr_o, 32'h4440);
            chk("t3_arlen_stable", bus.m_arlen_o, 2);
         end else if (arv > 0) begin
            break;
         end
      end
      chk("t3_arvalid_cycles", arv, 6);
      chk("t3_arready_low_cycles", arlow, 5);
      chk("t3_regrant", gcnt, 0);
      wait_idle("t3_idle");
      ar_delay = 0;

      // Error response on the second of four beats
      err_beat = 1;
      @(posedge clk); #1;
      bus.i_req_i = 1'b1; bus.i_addr_i = 32'h500; bus.i_len_i = 8'd3;
      @(negedge clk);
      @(posedge clk); #1;
      bus.i_req_i = 1'b0;
      collect_i(ib, last_at, dseen, emask);
      chk("t4_rerr_mask", emask, 8'b0000_0010);
      chk("t4_beats", ib, 4);
      chk("t4_rlast_beat", last_at, 4);
      @(negedge clk);
      chk("t4_back_to_idle", bus.m_rready_o, 0);
      err_beat = -2;

      // Reset during beat 2 of an eight-beat data burst
      @(posedge clk); #1;
      bus.d_req_i = 1'b1; bus.d_addr_i = 32'h600; bus.d_len_i = 8'd7;
      @(negedge clk);
      @(posedge clk); #1;
      bus.d_req_i = 1'b0;
      dcnt = 0;
      for (int c = 0; c < 30 && dcnt < 2; c++) begin
         @(negedge clk);
         if (bus.d_rvalid_o) dcnt++;
      end
      chk("t5_reached_beat2", dcnt, 2);
      #1 rst_n = 1'b0;
      #1;
      chk("t5_m_rvalid_still_high", bus.m_rvalid_i, 1);
      chk("t5_d_rvalid_async", bus.d_rvalid_o, 0);
      chk("t5_rready_async", bus.m_rready_o, 0);
      chk("t5_arvalid_async", bus.m_arvalid_o, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      bus.i_req_i = 1'b1; bus.i_addr_i = 32'h700; bus.i_len_i = 8'd0;
      bus.d_req_i = 1'b1; bus.d_addr_i = 32'h800; bus.d_len_i = 8'd0;
      @(negedge clk);
      chk("t5_first_gnt_i", bus.i_gnt_o, 1);
      chk("t5_first_gnt_not_d", bus.d_gnt_o, 0);
      @(posedge clk); #1;
      clear_reqs();
      wait_idle("t5_idle");

      // Randomized traffic, with one reset in the middle
      ar_delay = -1; gaps = 1'b1; err_beat = -1; spurious = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         ig = bus.i_gnt_o; dg = bus.d_gnt_o;
         @(posedge clk); #1;
         if (c == 1500) begin
            rst_n = 1'b0;
            clear_reqs();
         end else if (c == 1502) begin
            rst_n = 1'b1;
         end else if (rst_n) begin
            if (ig) bus.i_req_i = 1'b0;
            else if (!bus.i_req_i && $urandom_range(2) == 0) begin
               bus.i_req_i = 1'b1; bus.i_addr_i = $urandom; bus.i_len_i = 8'($urandom_range(5));
            end
            if (dg) bus.d_req_i = 1'b0;
            else if (!bus.d_req_i && $urandom_range(2) == 0) begin
               bus.d_req_i = 1'b1; bus.d_addr_i = $urandom; bus.d_len_i = 8'($urandom_range(5));
            end
         end
      end
      // Let any held request be granted, then stop requesting.
      for (int c = 0; c < 200 && (bus.i_req_i || bus.d_req_i); c++) begin
         @(negedge clk);
         ig = bus.i_gnt_o; dg = bus.d_gnt_o;
         @(posedge clk); #1;
         if (ig) bus.i_req_i = 1'b0;
         if (dg) bus.d_req_i = 1'b0;
      end
      chk("rand_reqs_drained", {bus.i_req_i, bus.d_req_i}, 0);
      clear_reqs();
      wait_idle("rand_idle");

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin : watchdog
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
